// File: rtl/pc_seq_if.sv
// Signal bundle between the PC sequencer, instruction memory, the decoder and the jump unit.
// The master modport is the sequencer's view; the slave modport is the view of everything around it.
interface pc_seq_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_done;
  logic               is_jump;
  logic [PC_W-1:0]    jump_target;
  logic [1:0]         cond;
  logic               halt;
  logic [PC_W-1:0]    pc;
  logic               jump_taken;
  logic               fault;
  logic [2:0]         state;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, jump_taken, fault, state,
    input  imem_ack, imem_data, exec_done, is_jump, jump_target, cond, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, jump_taken, fault, state,
    output imem_ack, imem_data, exec_done, is_jump, jump_target, cond, halt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over a req/ack handshake, hands instructions to decode,
// and resolves jumps one cycle after the jump completes. All outputs come straight from registers.
module pc_sequencer #(
  parameter int          PC_W         = 8,
  parameter int          INSTR_W      = 16,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int          ACK_TIMEOUT  = 15
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  pc_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_BRANCH  = 3'd3,
    S_HALTED  = 3'd4,
    S_FAULTED = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] RST_PC   = PC_W'(RESET_VECTOR);
  // Counter value seen during the last permitted wait cycle; an ack in that cycle still wins.
  localparam logic [7:0]      CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t             r_state,  w_state_next;
  logic [PC_W-1:0]    r_pc,     w_pc_next;
  logic [PC_W-1:0]    r_target, w_target_next;
  logic [INSTR_W-1:0] r_instr,  w_instr_next;
  logic               r_req,    w_req_next;
  logic               r_valid,  w_valid_next;
  logic               r_jt,     w_jt_next;
  logic               r_fault,  w_fault_next;
  logic [7:0]         r_cnt,    w_cnt_next;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_pc_inc = r_pc + PC_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RST_PC;
      r_target <= '0;
      r_instr  <= '0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_jt     <= 1'b0;
      r_fault  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
      r_instr  <= w_instr_next;
      r_req    <= w_req_next;
      r_valid  <= w_valid_next;
      r_jt     <= w_jt_next;
      r_fault  <= w_fault_next;
      r_cnt    <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    w_instr_next  = r_instr;
    w_req_next    = r_req;
    w_valid_next  = 1'b0;
    w_jt_next     = 1'b0;
    w_fault_next  = r_fault;
    w_cnt_next    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (bus.halt) begin
          w_state_next = S_HALTED;
        end else begin
          w_state_next = S_FETCH;
          w_req_next   = 1'b1;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          w_instr_next = bus.imem_data;
          w_valid_next = 1'b1;
          w_req_next   = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_fault_next = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = S_FAULTED;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.is_jump) begin
            w_target_next = bus.jump_target;
            w_state_next  = S_BRANCH;
          end else begin
            w_pc_next    = w_pc_inc;
            w_state_next = bus.halt ? S_HALTED : S_FETCH;
            w_req_next   = !bus.halt;
          end
        end
      end
      S_BRANCH: begin
        // The jump unit's flags have settled by this cycle, so COND is sampled here.
        if (bus.cond != 2'b00) begin
          w_pc_next = r_target;
          w_jt_next = 1'b1;
        end else begin
          w_pc_next = w_pc_inc;
        end
        w_state_next = bus.halt ? S_HALTED : S_FETCH;
        w_req_next   = !bus.halt;
      end
      S_HALTED: begin
        if (!bus.halt) begin
          w_state_next = S_FETCH;
          w_req_next   = 1'b1;
        end
      end
      S_FAULTED: begin
        w_state_next = S_FAULTED;
      end
      default: begin
        w_state_next = S_IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.jump_taken  = r_jt;
  assign bus.fault       = r_fault;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer; a per-instruction reference model predicts
// the next PC from the program rules (jump taken -> target, else PC+1 mod 256).
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] model_pc = 8'h00;

  always #5 clk = ~clk;

  pc_seq_if #(.PC_W(8), .INSTR_W(16)) bus ();

  pc_sequencer #(
    .PC_W(8), .INSTR_W(16), .RESET_VECTOR(0), .ACK_TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction starting with the sequencer in FETCH and the request visible.
  task automatic run_instr(input int ack_dly, input logic [15:0] data, input int exe_dly,
                           input logic jmp, input logic [7:0] tgt, input logic [1:0] cnd,
                           input logic hlt);
    logic [7:0] pc0;
    logic       taken;
    pc0 = model_pc;
    taken = jmp && (cnd != 2'b00);
    bus.halt = hlt;
    chk("fetch_state", 32'(bus.state), 32'd1);
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(pc0));
    for (int i = 0; i < ack_dly; i++) begin
      bus.exec_done = ($urandom_range(0, 1) == 1);
      bus.is_jump = ($urandom_range(0, 1) == 1);
      bus.jump_target = 8'($urandom);
      tick();
      bus.exec_done = 1'b0;
      bus.is_jump = 1'b0;
      chk("ack_wait_state", 32'(bus.state), 32'd1);
      chk("ack_wait_req", 32'(bus.imem_req), 32'd1);
      chk("ack_wait_fault", 32'(bus.fault), 32'd0);
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = data;
    tick();
    bus.imem_ack = 1'b0;
    chk("ack_instr", 32'(bus.instr), 32'(data));
    chk("ack_valid", 32'(bus.instr_valid), 32'd1);
    chk("ack_req_drop", 32'(bus.imem_req), 32'd0);
    chk("ack_state", 32'(bus.state), 32'd2);
    chk("ack_fault", 32'(bus.fault), 32'd0);
    for (int i = 0; i < exe_dly; i++) begin
      bus.imem_ack = ($urandom_range(0, 1) == 1);
      bus.imem_data = ~data;
      tick();
      bus.imem_ack = 1'b0;
      chk("exec_instr_hold", 32'(bus.instr), 32'(data));
      chk("exec_valid_low", 32'(bus.instr_valid), 32'd0);
      chk("exec_state", 32'(bus.state), 32'd2);
    end
    bus.exec_done = 1'b1;
    bus.is_jump = jmp;
    bus.jump_target = tgt;
    tick();
    bus.exec_done = 1'b0;
    bus.is_jump = 1'b0;
    bus.jump_target = 8'($urandom);
    if (jmp) begin
      chk("branch_state", 32'(bus.state), 32'd3);
      chk("branch_pc_hold", 32'(bus.pc), 32'(pc0));
      chk("branch_req", 32'(bus.imem_req), 32'd0);
      bus.cond = cnd;
      tick();
      bus.cond = 2'($urandom);
    end
    model_pc = taken ? tgt : pc0 + 8'd1;
    chk("jump_taken", 32'(bus.jump_taken), 32'(taken));
    chk("next_pc", 32'(bus.pc), 32'(model_pc));
    chk("next_state", 32'(bus.state), hlt ? 32'd4 : 32'd1);
    chk("next_req", 32'(bus.imem_req), hlt ? 32'd0 : 32'd1);
    if (hlt) begin
      tick();
      tick();
      chk("halt_state", 32'(bus.state), 32'd4);
      chk("halt_pc", 32'(bus.pc), 32'(model_pc));
      chk("halt_instr", 32'(bus.instr), 32'(data));
      chk("halt_jt_low", 32'(bus.jump_taken), 32'd0);
      bus.halt = 1'b0;
      tick();
      chk("resume_state", 32'(bus.state), 32'd1);
      chk("resume_req", 32'(bus.imem_req), 32'd1);
      chk("resume_addr", 32'(bus.imem_addr), 32'(model_pc));
    end
    $display("instr pc=%02h data=%04h jump=%0d cond=%0d halt=%0d -> next_pc=%02h",
             pc0, data, jmp, cnd, hlt, model_pc);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
    chk({tag, "_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_instr"}, 32'(bus.instr), 32'd0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_jt"}, 32'(bus.jump_taken), 32'd0);
    chk({tag, "_fault"}, 32'(bus.fault), 32'd0);
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    bus.exec_done = 1'b0;
    bus.is_jump = 1'b0;
    bus.jump_target = '0;
    bus.cond = 2'b00;
    bus.halt = 1'b0;

    // Reset values, then request rises one cycle after release.
    #12;
    check_reset_values("reset");
    #10;
    rst_n = 1'b1;
    tick();
    model_pc = 8'h00;
    chk("release_req", 32'(bus.imem_req), 32'd1);
    chk("release_state", 32'(bus.state), 32'd1);

    // Sequential fetch 0..4, ack after one cycle, exec done right after valid.
    for (int i = 0; i < 5; i++)
      run_instr(1, 16'($urandom), 0, 1'b0, 8'h00, 2'b00, 1'b0);

    // Taken jump at 5, back to 5, then not-taken jump at 5.
    run_instr(1, 16'hA5A5, 0, 1'b1, 8'h20, 2'b01, 1'b0);
    run_instr(0, 16'h1234, 1, 1'b1, 8'h05, 2'b11, 1'b0);
    run_instr(1, 16'hA5A5, 0, 1'b1, 8'h20, 2'b00, 1'b0);

    // Jump to 0xFF, wrap with halt raised, resume at 0, then a self-jump.
    run_instr(0, 16'h0F0F, 0, 1'b1, 8'hFF, 2'b10, 1'b0);
    run_instr(2, 16'hBEEF, 1, 1'b0, 8'h00, 2'b00, 1'b1);
    run_instr(0, 16'h5555, 0, 1'b1, 8'h00, 2'b01, 1'b0);
    run_instr(1, 16'h6666, 2, 1'b1, 8'h40, 2'b11, 1'b1);

    // Randomized program.
    for (int i = 0; i < 30; i++)
      run_instr($urandom_range(0, 5), 16'($urandom), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1), 8'($urandom), 2'($urandom),
                ($urandom_range(0, 3) == 0));

    // Timeout: no ack for 15 cycles faults; FAULTED ignores ack and exec_done.
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("to_wait_fault", 32'(bus.fault), 32'd0);
      chk("to_wait_req", 32'(bus.imem_req), 32'd1);
    end
    tick();
    chk("to_fault", 32'(bus.fault), 32'd1);
    chk("to_req_drop", 32'(bus.imem_req), 32'd0);
    chk("to_state", 32'(bus.state), 32'd5);
    bus.imem_ack = 1'b1;
    bus.exec_done = 1'b1;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    bus.exec_done = 1'b0;
    chk("faulted_stays", 32'(bus.state), 32'd5);
    chk("faulted_sticky", 32'(bus.fault), 32'd1);
    chk("faulted_pc_hold", 32'(bus.pc), 32'(model_pc));

    // Reset out of FAULTED, then an ack landing exactly on the 15th cycle.
    #2 rst_n = 1'b0;
    #1 check_reset_values("fault_reset");
    #2 rst_n = 1'b1;
    tick();
    model_pc = 8'h00;
    run_instr(14, 16'hC0DE, 0, 1'b0, 8'h00, 2'b00, 1'b0);

    // Reset mid-handshake: request drops before the next edge.
    chk("mid_req_before", 32'(bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    #2 rst_n = 1'b1;
    tick();
    model_pc = 8'h00;
    run_instr(1, 16'h7777, 0, 1'b0, 8'h00, 2'b00, 1'b0);
    run_instr(3, 16'h8888, 1, 1'b1, 8'h33, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
